// File: rtl/gppcu_flag_wb_stage.sv
// GPPCU execute/writeback stage: condition evaluation, NZCV flag register,
// carry feedback to the ALU and a 2-entry elastic buffer toward the register file.
module gppcu_flag_wb_stage #(
    parameter int unsigned BW = 32,
    parameter int unsigned RW = 4
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iVALID,
    output logic          oREADY,
    input  logic [BW-1:0] iQ,
    input  logic          iC,
    input  logic          iV,
    input  logic          iN,
    input  logic          iZ,
    input  logic [3:0]    iOP,
    input  logic [3:0]    iCOND,
    input  logic          iSETF,
    input  logic [RW-1:0] iRD,
    input  logic          iWE,
    output logic          oVALID,
    input  logic          iREADY,
    output logic [BW-1:0] oQ,
    output logic [RW-1:0] oRD,
    output logic          oWE,
    output logic [3:0]    oFLAGS,
    output logic          oCARRY
);

    // Buffer occupancy states
    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    localparam logic [3:0] OP_NOP  = 4'b0000;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic [BW-1:0] q;
        logic [RW-1:0] rd;
        logic          we;
    } entry_t;

    // Registered state
    logic [1:0] count;
    entry_t     headReg;
    entry_t     tailReg;
    logic [3:0] flags;
    logic       validReg;
    logic       readyReg;
    logic       weReg;

    // Next-state values
    logic [1:0] countNext;
    entry_t     headNext;
    entry_t     tailNext;
    logic [3:0] flagsNext;
    logic       validNext;
    logic       readyNext;
    logic       weNext;

    logic   condPass;
    logic   accept;
    logic   execute;
    logic   pop;
    entry_t inEntry;

    wire flagN = flags[3];
    wire flagZ = flags[2];
    wire flagC = flags[1];
    wire flagV = flags[0];

    assign inEntry = '{q: iQ, rd: iRD, we: iWE};

    // Condition check against the architectural flags held before this edge
    always_comb begin
        condPass = 1'b0;
        case (iCOND)
            COND_EQ: condPass = flagZ;
            COND_NE: condPass = !flagZ;
            COND_CS: condPass = flagC;
            COND_CC: condPass = !flagC;
            COND_MI: condPass = flagN;
            COND_PL: condPass = !flagN;
            COND_VS: condPass = flagV;
            COND_VC: condPass = !flagV;
            COND_AL: condPass = 1'b1;
            default: condPass = 1'b0;
        endcase
    end

    // Handshake qualification: failed conditions and NOPs are consumed without effect
    always_comb begin
        accept  = iVALID && readyReg;
        execute = accept && condPass && (iOP != OP_NOP);
        pop     = validReg && iREADY;
    end

    // Next-state logic for the buffer, flags and registered outputs
    always_comb begin
        countNext = count;
        headNext  = headReg;
        tailNext  = tailReg;
        flagsNext = flags;

        if (execute && iSETF) begin
            flagsNext = {iN, iZ, iC, iV};
        end

        case (count)
            CNT_EMPTY: begin
                // A pop request on an empty buffer is ignored
                if (execute) begin
                    headNext  = inEntry;
                    countNext = CNT_ONE;
                end
            end
            CNT_ONE: begin
                case ({execute, pop})
                    2'b11: headNext = inEntry;
                    2'b10: begin
                        tailNext  = inEntry;
                        countNext = CNT_FULL;
                    end
                    2'b01: countNext = CNT_EMPTY;
                    default: countNext = CNT_ONE;
                endcase
            end
            CNT_FULL: begin
                // oREADY is low when full, so only a pop can happen here
                if (pop) begin
                    headNext  = tailReg;
                    countNext = CNT_ONE;
                end
            end
            default: countNext = CNT_EMPTY;
        endcase

        validNext = (countNext != CNT_EMPTY);
        readyNext = (countNext != CNT_FULL);
        weNext    = headNext.we && validNext;
    end

    // State register; reset drops everything including in-flight flag updates
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            count    <= CNT_EMPTY;
            headReg  <= '0;
            tailReg  <= '0;
            flags    <= 4'b0000;
            validReg <= 1'b0;
            readyReg <= 1'b0;
            weReg    <= 1'b0;
        end else begin
            count    <= countNext;
            headReg  <= headNext;
            tailReg  <= tailNext;
            flags    <= flagsNext;
            validReg <= validNext;
            readyReg <= readyNext;
            weReg    <= weNext;
        end
    end

    // Outputs come straight from flops
    assign oREADY = readyReg;
    assign oVALID = validReg;
    assign oQ     = headReg.q;
    assign oRD    = headReg.rd;
    assign oWE    = weReg;
    assign oFLAGS = flags;
    assign oCARRY = flags[1];

endmodule

// File: tb/tb_gppcu_flag_wb_stage.sv
// Testbench for gppcu_flag_wb_stage: directed scenarios plus random traffic,
// all checked against a queue-based behavioural model.
module tb_gppcu_flag_wb_stage;

    logic        iCLK;
    logic        iRSTn;
    logic        iVALID;
    logic        oREADY;
    logic [31:0] iQ;
    logic        iC, iV, iN, iZ;
    logic [3:0]  iOP;
    logic [3:0]  iCOND;
    logic        iSETF;
    logic [3:0]  iRD;
    logic        iWE;
    logic        oVALID;
    logic        iREADY;
    logic [31:0] oQ;
    logic [3:0]  oRD;
    logic        oWE;
    logic [3:0]  oFLAGS;
    logic        oCARRY;

    int errCnt = 0;
    int chkCnt = 0;

    gppcu_flag_wb_stage #(.BW(32), .RW(4)) dut (
        .iCLK(iCLK), .iRSTn(iRSTn), .iVALID(iVALID), .oREADY(oREADY),
        .iQ(iQ), .iC(iC), .iV(iV), .iN(iN), .iZ(iZ),
        .iOP(iOP), .iCOND(iCOND), .iSETF(iSETF), .iRD(iRD), .iWE(iWE),
        .oVALID(oVALID), .iREADY(iREADY), .oQ(oQ), .oRD(oRD), .oWE(oWE),
        .oFLAGS(oFLAGS), .oCARRY(oCARRY)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Behavioural model state
    typedef struct packed {
        logic [31:0] q;
        logic [3:0]  rd;
        logic        we;
    } ent_t;

    ent_t       mq[$];
    ent_t       lastHead;
    logic [3:0] mFlags;
    logic       mReady;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Flag selected by cond[2:1] (Z, C, N, V), inverted when cond[0] is set
    function automatic bit condOk(input logic [3:0] f, input logic [3:0] c);
        logic [3:0] sel;
        if (c == 4'hE) return 1'b1;
        if (c[3]) return 1'b0;
        sel = {f[0], f[3], f[1], f[2]};
        return sel[c[2:1]] ^ c[0];
    endfunction

    task automatic modelReset();
        mq.delete();
        lastHead = '0;
        mFlags   = 4'b0000;
        mReady   = 1'b0;
    endtask

    task automatic checkAll();
        checkVal("oVALID", 64'(oVALID), 64'(mq.size() != 0));
        checkVal("oREADY", 64'(oREADY), 64'(mReady));
        checkVal("oFLAGS", 64'(oFLAGS), 64'(mFlags));
        checkVal("oCARRY", 64'(oCARRY), 64'(mFlags[1]));
        checkVal("oQ", 64'(oQ), 64'(lastHead.q));
        checkVal("oRD", 64'(oRD), 64'(lastHead.rd));
        checkVal("oWE", 64'(oWE), 64'((mq.size() != 0) && lastHead.we));
    endtask

    // Advance one clock: predict from inputs applied at the preceding negedge
    task automatic step();
        bit         ex;
        bit         pp;
        ent_t       e;
        ent_t       dropped;
        logic [3:0] newFlags;
        bit         setf;
        ex       = iVALID && mReady && condOk(mFlags, iCOND) && (iOP != 4'd0);
        pp       = (mq.size() != 0) && iREADY;
        e        = '{q: iQ, rd: iRD, we: iWE};
        newFlags = {iN, iZ, iC, iV};
        setf     = iSETF;
        @(posedge iCLK);
        #1;
        if (pp) dropped = mq.pop_front();
        if (ex) begin
            mq.push_back(e);
            if (setf) mFlags = newFlags;
        end
        if (mq.size() != 0) lastHead = mq[0];
        mReady = (mq.size() < 2);
        checkAll();
        @(negedge iCLK);
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] cond,
                         input logic setf, input logic [31:0] q, input logic [3:0] rd,
                         input logic we, input logic [3:0] nzcv, input logic rdy);
        iVALID = v;
        iOP    = op;
        iCOND  = cond;
        iSETF  = setf;
        iQ     = q;
        iRD    = rd;
        iWE    = we;
        {iN, iZ, iC, iV} = nzcv;
        iREADY = rdy;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iRSTn = 1'b0;
        drive(1'b0, 4'd0, 4'hE, 1'b0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        modelReset();

        // Reset state before any clock
        #3;
        checkAll();
        @(negedge iCLK);
        @(negedge iCLK);
        checkVal("ready_in_reset", 64'(oREADY), 64'd0);
        iRSTn = 1'b1;
        step();
        checkVal("ready_after_release", 64'(oREADY), 64'd1);

        // AL MOV: visible next cycle, flags stay clear
        drive(1'b1, 4'd1, 4'hE, 1'b1, 32'h12345678, 4'd3, 1'b1, 4'b0000, 1'b1);
        step();
        checkVal("mov_valid", 64'(oVALID), 64'd1);
        checkVal("mov_q", 64'(oQ), 64'h12345678);
        checkVal("mov_rd", 64'(oRD), 64'd3);
        checkVal("mov_flags", 64'(oFLAGS), 64'd0);

        // ADI sets Z and C, then ADC under CS executes
        drive(1'b1, 4'd2, 4'hE, 1'b1, 32'h00000000, 4'd4, 1'b1, 4'b0110, 1'b1);
        step();
        checkVal("adi_flags", 64'(oFLAGS), 64'b0110);
        checkVal("adi_carry", 64'(oCARRY), 64'd1);
        drive(1'b1, 4'd3, 4'h2, 1'b0, 32'h00000A5C, 4'd5, 1'b1, 4'b0000, 1'b1);
        step();
        checkVal("adc_valid", 64'(oVALID), 64'd1);
        checkVal("adc_q", 64'(oQ), 64'h00000A5C);

        // Clear Z, then EQ is consumed silently and NE pushes
        drive(1'b1, 4'd1, 4'hE, 1'b1, 32'h1, 4'd1, 1'b0, 4'b0000, 1'b1);
        step();
        drive(1'b1, 4'd1, 4'h0, 1'b1, 32'hDEAD, 4'd6, 1'b1, 4'b1111, 1'b1);
        step();
        checkVal("eq_ready", 64'(oREADY), 64'd1);
        checkVal("eq_novalid", 64'(oVALID), 64'd0);
        checkVal("eq_flags", 64'(oFLAGS), 64'd0);
        drive(1'b1, 4'd1, 4'h1, 1'b0, 32'hBEEF, 4'd7, 1'b1, 4'b0000, 1'b1);
        step();
        checkVal("ne_valid", 64'(oVALID), 64'd1);
        checkVal("ne_q", 64'(oQ), 64'hBEEF);

        // Backpressure: A, B buffered, C stalls, then all drain in order
        drive(1'b0, 4'd0, 4'hE, 1'b0, 32'h0, 4'd0, 1'b0, 4'b0000, 1'b1);
        step();
        drive(1'b1, 4'd1, 4'hE, 1'b0, 32'hA, 4'd10, 1'b1, 4'b0000, 1'b0);
        step();
        drive(1'b1, 4'd1, 4'hE, 1'b0, 32'hB, 4'd11, 1'b1, 4'b0000, 1'b0);
        step();
        checkVal("full_ready", 64'(oREADY), 64'd0);
        drive(1'b1, 4'd1, 4'hE, 1'b0, 32'hC, 4'd12, 1'b1, 4'b0000, 1'b0);
        step();
        checkVal("stall_headA", 64'(oQ), 64'hA);
        step();
        checkVal("stall_headA2", 64'(oQ), 64'hA);
        iREADY = 1'b1;
        step();
        checkVal("drain_B", 64'(oQ), 64'hB);
        step();
        checkVal("drain_C", 64'(oQ), 64'hC);
        iVALID = 1'b0;
        step();
        checkVal("drain_empty", 64'(oVALID), 64'd0);
        checkVal("empty_we", 64'(oWE), 64'd0);

        // NOP with SETF leaves flags and buffer untouched
        drive(1'b1, 4'd0, 4'hE, 1'b1, 32'h55, 4'd2, 1'b1, 4'b1000, 1'b1);
        step();
        checkVal("nop_valid", 64'(oVALID), 64'd0);
        checkVal("nop_flags", 64'(oFLAGS), 64'd0);

        // Two entries buffered, flags 1111, then asynchronous reset
        drive(1'b1, 4'd1, 4'hE, 1'b1, 32'h77, 4'd8, 1'b1, 4'b1111, 1'b0);
        step();
        drive(1'b1, 4'd1, 4'hE, 1'b0, 32'h88, 4'd9, 1'b1, 4'b0000, 1'b0);
        step();
        checkVal("pre_rst_flags", 64'(oFLAGS), 64'hF);
        iRSTn = 1'b0;
        #1;
        modelReset();
        checkVal("rst_valid", 64'(oVALID), 64'd0);
        checkVal("rst_flags", 64'(oFLAGS), 64'd0);
        checkVal("rst_carry", 64'(oCARRY), 64'd0);
        checkVal("rst_ready", 64'(oREADY), 64'd0);
        @(posedge iCLK);
        #1;
        checkAll();
        @(negedge iCLK);
        iRSTn = 1'b1;
        drive(1'b0, 4'd0, 4'hE, 1'b0, 32'h0, 4'd0, 1'b0, 4'b0000, 1'b1);
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            iVALID = ($urandom_range(0, 3) != 0);
            iOP    = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            iCOND  = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            iSETF  = 1'($urandom_range(0, 1));
            iQ     = $urandom;
            iRD    = 4'($urandom_range(0, 15));
            iWE    = 1'($urandom_range(0, 1));
            {iN, iZ, iC, iV} = 4'($urandom_range(0, 15));
            iREADY = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
